// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// State encodings are fixed because they are exported on state_dbg.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT     = 50000;
    localparam int unsigned DEF_STABLE_CYCLES    = 1024;
    localparam int unsigned DEF_MAX_RETRIES      = 3;
    localparam int unsigned DEF_CNT_W            = 16;

    // Saturating increment; the retry count never exceeds its limit
    function automatic logic [1:0] sat_inc2(input logic [1:0] val, input logic [1:0] lim);
        logic [1:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer; both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the reference-clock domain: pulses pll_rst, waits
// for lock with timeout and bounded retries, then qualifies lock before release.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES    = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic       lost_lock,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    pll_state_e       state_r;
    pll_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [1:0]       retry_cnt_r;
    logic [1:0]       retry_next_s;
    logic [1:0]       retry_inc_s;
    logic             lost_next_s;
    logic             locked_s;
    logic             pll_rst_r;
    logic             sys_reset_n_r;
    logic             ready_r;
    logic             fail_r;
    logic             lost_lock_r;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state, counter and retry bookkeeping
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        retry_next_s = retry_cnt_r;
        lost_next_s  = 1'b0;
        retry_inc_s  = sat_inc2(retry_cnt_r, RETRY_MAX);
        case (state_r)
            RESET_HOLD: begin
                if (cnt_r == RST_LAST) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = WAIT_LOCK;
                end else begin
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WAIT_LOCK: begin
                // Lock beats the timeout when both land on the same cycle
                if (locked_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    retry_next_s = retry_inc_s;
                    if (retry_inc_s == RETRY_MAX) begin
                        state_next_s = FAIL;
                    end else begin
                        state_next_s = RESET_HOLD;
                    end
                end else begin
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    retry_next_s = 2'd0;
                    state_next_s = RUN;
                end else begin
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (!locked_s || relock_req) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    lost_next_s  = !locked_s;
                    state_next_s = RESET_HOLD;
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                end
            end
            FAIL: begin
                if (relock_req) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    retry_next_s = 2'd0;
                    state_next_s = RESET_HOLD;
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                cnt_next_s   = {CNT_W{1'b0}};
                retry_next_s = 2'd0;
                state_next_s = RESET_HOLD;
            end
        endcase
    end

    // State, counter and outputs; outputs are decoded from the next state so
    // they line up with the cycle the state register shows that state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RESET_HOLD;
            cnt_r         <= {CNT_W{1'b0}};
            retry_cnt_r   <= 2'd0;
            pll_rst_r     <= 1'b1;
            sys_reset_n_r <= 1'b0;
            ready_r       <= 1'b0;
            fail_r        <= 1'b0;
            lost_lock_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            retry_cnt_r   <= retry_next_s;
            pll_rst_r     <= (state_next_s == RESET_HOLD) || (state_next_s == FAIL);
            sys_reset_n_r <= (state_next_s == RUN);
            ready_r       <= (state_next_s == RUN);
            fail_r        <= (state_next_s == FAIL);
            lost_lock_r   <= lost_next_s;
        end
    end

    assign pll_rst     = pll_rst_r;
    assign sys_reset_n = sys_reset_n_r;
    assign ready       = ready_r;
    assign fail        = fail_r;
    assign lost_lock   = lost_lock_r;
    assign retry_cnt   = retry_cnt_r;
    assign state_dbg   = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic       lost_lock;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES (4),
        .LOCK_TIMEOUT     (100),
        .STABLE_CYCLES    (8),
        .MAX_RETRIES      (3),
        .CNT_W            (16)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fail        (fail),
        .lost_lock   (lost_lock),
        .retry_cnt   (retry_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 refclk = ~refclk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic prst,
                              input logic srn, input logic rdy, input logic fl,
                              input logic ll, input logic [1:0] rc);
        check_val({tag, ".state"}, 32'(state_dbg), 32'(st));
        check_val({tag, ".pll_rst"}, 32'(pll_rst), 32'(prst));
        check_val({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(srn));
        check_val({tag, ".ready"}, 32'(ready), 32'(rdy));
        check_val({tag, ".fail"}, 32'(fail), 32'(fl));
        check_val({tag, ".lost_lock"}, 32'(lost_lock), 32'(ll));
        check_val({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Nominal lock: pll_rst high for 4 edges, lock 20 cycles after release
        tick(3);
        check_val("nom.pulse_hi", 32'(pll_rst), 32'd1);
        tick(1);
        check_outs("nom.wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(20);
        pll_locked = 1'b1;
        tick(3);
        check_val("nom.stable_entry", 32'(state_dbg), 32'd2);
        tick(7);
        check_val("nom.ready_early", 32'(ready), 32'd0);
        tick(1);
        check_outs("nom.run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Lock loss in RUN: visible three edges after the drop
        tick(4);
        pll_locked = 1'b0;
        tick(2);
        check_val("loss.still_run", 32'(sys_reset_n), 32'd1);
        tick(1);
        check_outs("loss.hit", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        tick(1);
        check_val("loss.pulse_end", 32'(lost_lock), 32'd0);
        tick(2);
        check_val("loss.rst_pulse", 32'(pll_rst), 32'd1);
        tick(1);
        check_outs("loss.wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Glitch at stable count 5 sends the sequence back to WAIT_LOCK
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check_outs("glitch.back", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(1);
        check_val("glitch.restable", 32'(state_dbg), 32'd2);
        tick(7);
        check_val("glitch.ready_early", 32'(ready), 32'd0);
        tick(1);
        check_outs("glitch.run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Relock request on the same cycle the synchronized lock drops
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("both.hit", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        pll_locked = 1'b1;
        tick(1);
        check_val("both.single", 32'(lost_lock), 32'd0);
        check_val("both.hold", 32'(state_dbg), 32'd0);
        tick(3);
        check_val("both.wait", 32'(state_dbg), 32'd1);
        tick(9);
        check_outs("both.run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Relock request alone
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("req.hit", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Never lock: three timeouts 104 cycles apart, then FAIL
        pll_locked = 1'b0;
        tick(4);
        check_val("to.wait", 32'(state_dbg), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick(99);
            check_val("to.pre_state", 32'(state_dbg), 32'd1);
            check_val("to.pre_retry", 32'(retry_cnt), 32'(k - 1));
            check_val("to.pre_rst", 32'(pll_rst), 32'd0);
            tick(1);
            check_val("to.retry", 32'(retry_cnt), 32'(k));
            check_val("to.rst", 32'(pll_rst), 32'd1);
            if (k < 3) begin
                check_val("to.hold", 32'(state_dbg), 32'd0);
                tick(4);
                check_val("to.rewait", 32'(state_dbg), 32'd1);
            end else begin
                check_outs("to.fail", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
            end
        end
        tick(5);
        check_outs("fail.held", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("fail.exit", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Async reset at WAIT_LOCK count 50, then full restart
        tick(4);
        check_val("ar.wait", 32'(state_dbg), 32'd1);
        tick(50);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("ar.async", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(3);
        check_val("ar.pulse_hi", 32'(pll_rst), 32'd1);
        tick(1);
        check_val("ar.pulse_lo", 32'(pll_rst), 32'd0);
        tick(99);
        check_val("ar.no_early_timeout", 32'(state_dbg), 32'd1);
        tick(1);
        check_outs("ar.timeout", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
